// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: frame width default, clock
// polarity, the responder state encoding and a counter-width helper.
package spi_pkg;

  // Default frame length in bits (rx and tx word width)
  localparam int SPI_FRAME_WIDTH = 136;

  // sclk idle level; the master drives sclk high between frames
  localparam logic SPI_CPOL = 1'b1;

  // Default synchronizer depth for the asynchronous SPI pins
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  // The bit counter must reach W+1 so a long frame is distinguishable
  // from an exact one without wrapping.
  function automatic int spi_cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, followed by edge
// detection on the synchronized level. The strobes compare the last sync
// stage with a one-cycle delayed copy, so each is high for exactly one clk.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              dly_q;
  logic              dly_d;

  // Shift the pin value through the sync chain; remember the previous level
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    dly_d  = sync_q[STAGES-1];
  end

  // Sync chain and delay register, reset to the pin's idle level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  =  sync_q[STAGES-1] & ~dly_q;
  assign fall_o  = ~sync_q[STAGES-1] &  dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder, CPOL=1: samples mosi on sclk falling edges, shifts miso
// on sclk rising edges, one frame per ss low period, MSB first. All SPI
// pins are oversampled in the clk domain.
//
// Optional build macro: SPI_SLAVE_MISO_OE_EN adds a miso_oe output (equal
// to busy) and forces miso low whenever miso_oe is low.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no frame; waiting for ss fall, sclk edges ignored
// ACTIVE | frame in progress; counting/sampling sclk edges until ss rise
module spi_slave
  import spi_pkg::*;
#(
  parameter int INPUT_WIDTH = SPI_FRAME_WIDTH,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sclk,
  input  logic                   ss,
  input  logic                   mosi,
  output logic                   miso,
`ifdef SPI_SLAVE_MISO_OE_EN
  output logic                   miso_oe,
`endif
  input  logic [INPUT_WIDTH-1:0] tx_data,
  output logic [INPUT_WIDTH-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic                   busy
);

  localparam int W  = INPUT_WIDTH;
  localparam int CW = spi_cnt_width(INPUT_WIDTH);

  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_SAT  = CW'(W + 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (SPI_CPOL)
  ) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .d_i     (sclk),
    .level_o (sclk_s),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  // ss resets to "selected" so a select held low through reset produces
  // no falling edge and therefore never starts a frame.
  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sync_ss (
    .clk     (clk),
    .rst     (rst),
    .d_i     (ss),
    .level_o (ss_s),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sync_mosi (
    .clk     (clk),
    .rst     (rst),
    .d_i     (mosi),
    .level_o (mosi_s),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  spi_state_e      state_q, state_d;
  logic [W-1:0]    tx_shift_q, tx_shift_d;
  logic [W-1:0]    rx_shift_q, rx_shift_d;
  logic [W-1:0]    rx_data_q, rx_data_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            busy_q, busy_d;
  logic            ok_pend_q, ok_pend_d;
  logic            err_pend_q, err_pend_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;

  // Frame FSM: load on ss fall, shift on sclk edges, judge bit count on ss rise.
  // The verdict is staged one cycle before it becomes a pulse, so rx_data is
  // already stable when rx_valid is seen.
  always_comb begin
    state_d     = state_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    busy_d      = busy_q;
    ok_pend_d   = 1'b0;
    err_pend_d  = 1'b0;
    rx_valid_d  = ok_pend_q;
    frame_err_d = err_pend_q;

    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          tx_shift_d = tx_data;
          rx_shift_d = '0;
          bit_cnt_d  = '0;
          busy_d     = 1'b1;
          state_d    = ACTIVE;
        end
      end

      ACTIVE: begin
        if (ss_rise) begin
          // End of frame takes priority over any coincident sclk edge
          busy_d  = 1'b0;
          state_d = IDLE;
          if (bit_cnt_q == CNT_FULL) begin
            rx_data_d = rx_shift_q;
            ok_pend_d = 1'b1;
          end else begin
            err_pend_d = 1'b1;
          end
        end else begin
          if (sclk_fall) begin
            rx_shift_d = {rx_shift_q[W-2:0], mosi_s};
            if (bit_cnt_q != CNT_SAT) begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
          if (sclk_rise) begin
            tx_shift_d = {tx_shift_q[W-2:0], 1'b0};
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      busy_q      <= 1'b0;
      ok_pend_q   <= 1'b0;
      err_pend_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      busy_q      <= busy_d;
      ok_pend_q   <= ok_pend_d;
      err_pend_q  <= err_pend_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

`ifdef SPI_SLAVE_MISO_OE_EN
  assign miso_oe = busy_q;
  assign miso    = busy_q & tx_shift_q[W-1];
`else
  assign miso    = tx_shift_q[W-1];
`endif

  // Synchronized sclk/ss levels are only consumed through their edge strobes
  logic sync_levels_unused;
  assign sync_levels_unused = sclk_s ^ ss_s;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-level SPI master model (half-bit of
// 8 clk) drives frames; expected words and pulse counts are hand-chosen.
module tb_spi_slave;
  import spi_pkg::*;

  localparam int W  = 136;
  localparam int HB = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk, ss, mosi, miso;
  logic [W-1:0] tx_data, rx_data;
  logic         rx_valid, frame_err, busy;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic         miso_oe;
`endif

  spi_slave #(.INPUT_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .ss        (ss),
    .mosi      (mosi),
    .miso      (miso),
`ifdef SPI_SLAVE_MISO_OE_EN
    .miso_oe   (miso_oe),
`endif
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int n_valid = 0;
  int n_ferr = 0;

  // Pulse counters, sampled on the inactive edge
  always @(negedge clk) begin
    if (rx_valid)  n_valid++;
    if (frame_err) n_ferr++;
  end

  logic [W-1:0] sh_mo;
  logic [W-1:0] cap;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_begin(input logic [W-1:0] mo);
    sh_mo = mo;
    cap   = '0;
    ss    = 1'b0;
    mosi  = sh_mo[W-1];
    clks(HB);
  endtask

  task automatic clock_bits(input int n);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0;
      cap  = {cap[W-2:0], miso};
      clks(HB);
      sclk  = 1'b1;
      sh_mo = sh_mo << 1;
      mosi  = sh_mo[W-1];
      clks(HB);
    end
  endtask

  // Raise ss and return the clk count until a pulse appears (0 if none in 20)
  task automatic frame_end(output int lat);
    lat = 0;
    ss  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      clks(1);
      if (lat == 0 && (rx_valid || frame_err)) lat = k;
    end
  endtask

  localparam logic [W-1:0] M_A5 = {17{8'hA5}};
  localparam logic [W-1:0] T_A  = 136'h01_2345_6789_ABCD_EF01_2345_6789_ABCD_CDEF;
  localparam logic [W-1:0] M1   = {17{8'h3C}};
  localparam logic [W-1:0] M2   = {8'h5A, 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978};
  localparam logic [W-1:0] T1   = {8'hC3, 128'h11112222_33334444_55556666_77778888};
  localparam logic [W-1:0] T2   = {8'h3C, 128'h9999AAAA_BBBBCCCC_DDDDEEEE_FFFF0000};
  localparam logic [W-1:0] M3   = {8'h77, 128'h0};
  localparam logic [W-1:0] M4   = {8'h96, 128'h13579BDF_2468ACE0_F0E1D2C3_B4A59687};
  localparam logic [W-1:0] T3   = {8'hE7, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0};

  int lat;
  int v0, e0;
  logic [W-1:0] cap1;

  initial begin
    rst = 1'b1; ss = 1'b1; sclk = 1'b1; mosi = 1'b0; tx_data = '0;
    clks(5);

    // Reset state
    chk("rst_miso", miso, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
`ifdef SPI_SLAVE_MISO_OE_EN
    chk("rst_miso_oe", miso_oe, 0);
`endif
    rst = 1'b0;
    clks(10);
    chk("idle_busy", busy, 0);
`ifdef SPI_SLAVE_MISO_OE_EN
    chk("idle_miso_oe", miso_oe, 0);
    chk("idle_miso", miso, 0);
`endif

    // Nominal frame
    tx_data = T_A;
    v0 = n_valid; e0 = n_ferr;
    frame_begin(M_A5);
    chk("nom_busy", busy, 1);
    chk("nom_miso_msb", miso, T_A[W-1]);
`ifdef SPI_SLAVE_MISO_OE_EN
    chk("nom_miso_oe", miso_oe, 1);
`endif
    clock_bits(W);
    frame_end(lat);
    chk("nom_latency", lat, 4);
    chk("nom_rx_data", rx_data, M_A5);
    chk("nom_capture", cap, T_A);
    chk("nom_valid_cnt", n_valid - v0, 1);
    chk("nom_err_cnt", n_ferr - e0, 0);
    chk("nom_busy_end", busy, 0);

    // Short frame: 8 bits of 0xFF
    v0 = n_valid; e0 = n_ferr;
    frame_begin({8'hFF, 128'h0});
    clock_bits(8);
    frame_end(lat);
    chk("short_latency", lat, 4);
    chk("short_err_cnt", n_ferr - e0, 1);
    chk("short_valid_cnt", n_valid - v0, 0);
    chk("short_rx_data", rx_data, M_A5);

    // Back-to-back frames, 3 clk gap; tx_data changed mid-frame has no effect
    v0 = n_valid; e0 = n_ferr;
    tx_data = T1;
    frame_begin(M1);
    clock_bits(60);
    tx_data = T2;
    clock_bits(W - 60);
    cap1 = cap;
    ss = 1'b1;
    clks(3);
    frame_begin(M2);
    clock_bits(W);
    frame_end(lat);
    chk("b2b_capture1", cap1, T1);
    chk("b2b_capture2", cap, T2);
    chk("b2b_rx_data", rx_data, M2);
    chk("b2b_valid_cnt", n_valid - v0, 2);
    chk("b2b_err_cnt", n_ferr - e0, 0);

    // Reset mid-frame, then finish the frame with ss low throughout
    v0 = n_valid; e0 = n_ferr;
    tx_data = T3;
    frame_begin(M3);
    clock_bits(50);
    chk("rstmid_busy_before", busy, 1);
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    clks(1);
    chk("rstmid_busy_after", busy, 0);
    clock_bits(W - 50);
    chk("rstmid_busy_held_ss", busy, 0);
    frame_end(lat);
    chk("rstmid_no_pulse", lat, 0);
    chk("rstmid_valid_cnt", n_valid - v0, 0);
    chk("rstmid_err_cnt", n_ferr - e0, 0);
    chk("rstmid_rx_data", rx_data, 0);

    // Proper frame after reset
    v0 = n_valid; e0 = n_ferr;
    frame_begin(M4);
    clock_bits(W);
    frame_end(lat);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_rx_data", rx_data, M4);
    chk("post_rst_capture", cap, T3);
    chk("post_rst_valid_cnt", n_valid - v0, 1);

    // Long frame: one extra falling edge
    v0 = n_valid; e0 = n_ferr;
    frame_begin(M1);
    clock_bits(W + 1);
    frame_end(lat);
    chk("long_latency", lat, 4);
    chk("long_err_cnt", n_ferr - e0, 1);
    chk("long_valid_cnt", n_valid - v0, 0);
    chk("long_rx_data", rx_data, M4);
    chk("long_busy", busy, 0);
`ifdef SPI_SLAVE_MISO_OE_EN
    chk("end_miso_oe", miso_oe, 0);
    chk("end_miso", miso, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
